// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic SLV_GPIO = 1'b0;
  localparam logic SLV_UART = 1'b1;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// master: the bridge's view; slave: the requester + APB slaves' view.
interface apb_master_bridge_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_rdata;
  logic                     rsp_err;
  logic [ADDRESS_WIDTH-1:0] PADDR;
  logic                     PSEL1;
  logic                     PSEL2;
  logic                     PENABLE;
  logic                     PWRITE;
  logic [DATA_WIDTH-1:0]    PWDATA;
  logic [DATA_WIDTH-1:0]    PRDATA1;
  logic [DATA_WIDTH-1:0]    PRDATA2;
  logic                     PREADY1;
  logic                     PREADY2;
  logic                     PSLVERR1;
  logic                     PSLVERR2;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  PRDATA1, PRDATA2, PREADY1, PREADY2, PSLVERR1, PSLVERR2,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output PADDR, PSEL1, PSEL2, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output PRDATA1, PRDATA2, PREADY1, PREADY2, PSLVERR1, PSLVERR2,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PADDR, PSEL1, PSEL2, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_slave_mux.sv
// Selects the ready/data/error return path of the currently addressed APB slave.
module apb_slave_mux
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  slv,
  input  logic                  pready1,
  input  logic                  pready2,
  input  logic                  pslverr1,
  input  logic                  pslverr2,
  input  logic [DATA_WIDTH-1:0] prdata1,
  input  logic [DATA_WIDTH-1:0] prdata2,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata
);

  // return-path selection by registered slave index
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    case (slv)
      SLV_GPIO: begin
        pready  = pready1;
        pslverr = pslverr1;
        prdata  = prdata1;
      end
      SLV_UART: begin
        pready  = pready2;
        pslverr = pslverr2;
        prdata  = prdata2;
      end
      default: begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
      end
    endcase
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: valid/ready command in, SETUP/ACCESS toward GPIO (PSEL1) or UART (PSEL2).
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int SEL_BIT        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_master_bridge_if.master bus
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ~(ADDRESS_WIDTH'(1'b1) << SEL_BIT);

  apb_state_t            state;
  logic                  slv;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  apb_slave_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .slv      (slv),
    .pready1  (bus.PREADY1),
    .pready2  (bus.PREADY2),
    .pslverr1 (bus.PSLVERR1),
    .pslverr2 (bus.PSLVERR2),
    .prdata1  (bus.PRDATA1),
    .prdata2  (bus.PRDATA2),
    .pready   (sel_ready),
    .pslverr  (sel_err),
    .prdata   (sel_rdata)
  );

  // transfer FSM with all bus and response outputs registered
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state         <= IDLE;
      slv           <= SLV_GPIO;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.PADDR     <= '0;
      bus.PSEL1     <= 1'b0;
      bus.PSEL2     <= 1'b0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PWDATA    <= '0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.PADDR     <= bus.req_addr & ADDR_MASK;
            bus.PWRITE    <= bus.req_write;
            bus.PWDATA    <= bus.req_wdata;
            slv           <= bus.req_addr[SEL_BIT];
            bus.PSEL1     <= (bus.req_addr[SEL_BIT] == SLV_GPIO);
            bus.PSEL2     <= (bus.req_addr[SEL_BIT] == SLV_UART);
            bus.req_ready <= 1'b0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          tmo_cnt     <= '0;
`endif
          state       <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= sel_err;
            bus.rsp_rdata <= bus.PWRITE ? '0 : sel_rdata;
            bus.PSEL1     <= 1'b0;
            bus.PSEL2     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          // this low-PREADY cycle is the TIMEOUT_CYCLES-th one: give up
          else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.PSEL1     <= 1'b0;
            bus.PSEL2     <= 1'b0;
            bus.PENABLE   <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        default: begin
          bus.PSEL1     <= 1'b0;
          bus.PSEL2     <= 1'b0;
          bus.PENABLE   <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized self-checking bench for apb_master_bridge with a per-cycle expectation table.
module tb_apb_master_bridge;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SB  = 4;
  localparam int TMO = 4;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;

  apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  apb_master_bridge #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .SEL_BIT(SB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct packed {
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pwrite;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_err;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] rsp_rdata;
  } exp_t;

  exp_t exp_tab[int];
  exp_t mdl;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 1'b0;
  int   last_rsp_cyc = -1;

  function automatic exp_t rst_exp();
    exp_t e;
    e = '0;
    e.req_ready = 1'b1;
    return e;
  endfunction

  task automatic chk1(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, expv);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
    end
  endtask

  // Every cycle: compare DUT outputs against the planned or idle expectation
  always @(negedge PCLK) begin
    if (chk_en) begin
      exp_t e;
      if (exp_tab.exists(cyc)) begin
        e = exp_tab[cyc];
        exp_tab.delete(cyc);
      end else begin
        e = mdl;
      end
      chk1("psel1", bus.PSEL1, e.psel1);
      chk1("psel2", bus.PSEL2, e.psel2);
      chk1("penable", bus.PENABLE, e.penable);
      chk1("pwrite", bus.PWRITE, e.pwrite);
      chk1("req_ready", bus.req_ready, e.req_ready);
      chk1("rsp_valid", bus.rsp_valid, e.rsp_valid);
      chk1("rsp_err", bus.rsp_err, e.rsp_err);
      chk32("paddr", bus.PADDR, e.paddr);
      chk32("pwdata", bus.PWDATA, e.pwdata);
      chk32("rsp_rdata", bus.rsp_rdata, e.rsp_rdata);
      if (bus.rsp_valid === 1'b1) last_rsp_cyc = cyc;
    end
  end

  // Expected bus view for a request whose SETUP cycle is a and with w PREADY-low ACCESS cycles.
  task automatic plan(input int a, input logic wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int w,
                      input logic err, output int rc, output exp_t post);
    exp_t          e;
    logic [AW-1:0] pa;
    logic          sel;
    int            n;
    bit            to;
    pa     = addr;
    pa[SB] = 1'b0;
    sel    = addr[SB];
    to     = 1'b0;
    n      = w + 1;
`ifdef APB_TIMEOUT_EN
    if (w >= TMO) begin
      to = 1'b1;
      n  = TMO;
    end
`endif
    e           = mdl;
    e.psel1     = !sel;
    e.psel2     = sel;
    e.penable   = 1'b0;
    e.req_ready = 1'b0;
    e.rsp_valid = 1'b0;
    e.paddr     = pa;
    e.pwdata    = wd;
    e.pwrite    = wr;
    exp_tab[a]  = e;
    e.penable   = 1'b1;
    for (int i = 1; i <= n; i++) exp_tab[a+i] = e;
    rc          = a + n + 1;
    e.psel1     = 1'b0;
    e.psel2     = 1'b0;
    e.penable   = 1'b0;
    e.req_ready = 1'b1;
    e.rsp_valid = 1'b1;
    e.rsp_err   = to ? 1'b1 : err;
    e.rsp_rdata = (to || wr) ? '0 : rd;
    exp_tab[rc] = e;
    post           = e;
    post.rsp_valid = 1'b0;
  endtask

  task automatic rand_slaves();
    bus.PREADY1  = 1'($urandom_range(0, 1));
    bus.PREADY2  = 1'($urandom_range(0, 1));
    bus.PSLVERR1 = 1'($urandom_range(0, 1));
    bus.PSLVERR2 = 1'($urandom_range(0, 1));
    bus.PRDATA1  = $urandom;
    bus.PRDATA2  = $urandom;
  endtask

  task automatic drive_sel(input logic sel, input logic rdy, input logic [DW-1:0] rd, input logic err);
    if (sel) begin
      bus.PREADY2  = rdy;
      bus.PRDATA2  = rd;
      bus.PSLVERR2 = err;
    end else begin
      bus.PREADY1  = rdy;
      bus.PRDATA1  = rd;
      bus.PSLVERR1 = err;
    end
  endtask

  // Call at #1 into an idle cycle; returns SETUP cycle a and response cycle rc.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd, input int w, input logic err, input int gap,
                        output int a, output int rc);
    exp_t post;
    logic sel;
    sel           = addr[SB];
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    a = cyc + 1;
    plan(a, wr, addr, wd, rd, w, err, rc, post);
    @(posedge PCLK); #1;
    while (cyc < rc) begin
      rand_slaves();
      drive_sel(sel, (cyc >= a + 1 + w), rd, err);
      if (cyc == rc - 1) begin
        bus.req_valid = 1'b0;
      end else begin
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
      end
      @(posedge PCLK); #1;
    end
    mdl = post;
    bus.req_valid = 1'b0;
    rand_slaves();
    repeat (gap) begin
      @(posedge PCLK); #1;
      rand_slaves();
    end
  endtask

  // Request to UART with PREADY low, then reset asserted in the second ACCESS cycle.
  task automatic do_abort();
    exp_t post;
    int   a;
    int   rc;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h0000_0014;
    bus.req_wdata = 32'h1234_5678;
    a = cyc + 1;
    plan(a, 1'b1, 32'h0000_0014, 32'h1234_5678, 32'h0, 10, 1'b0, rc, post);
    @(posedge PCLK); #1;
    while (cyc < a + 2) begin
      bus.req_valid = 1'b0;
      drive_sel(1'b1, 1'b0, 32'h0, 1'b0);
      @(posedge PCLK); #1;
    end
    PRESET = 1'b1;
    drive_sel(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = a + 3; i <= rc; i++) begin
      if (exp_tab.exists(i)) exp_tab.delete(i);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    mdl    = rst_exp();
    chk1("abort_psel2", bus.PSEL2, 1'b0);
    chk1("abort_penable", bus.PENABLE, 1'b0);
    chk1("abort_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("abort_req_ready", bus.req_ready, 1'b1);
    @(posedge PCLK); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int rc;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PREADY1   = 1'b0;
    bus.PREADY2   = 1'b0;
    bus.PSLVERR1  = 1'b0;
    bus.PSLVERR2  = 1'b0;
    bus.PRDATA1   = '0;
    bus.PRDATA2   = '0;
    mdl = rst_exp();
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    chk_en = 1'b1;
    chk1("rst_req_ready", bus.req_ready, 1'b1);
    chk1("rst_psel", bus.PSEL1 | bus.PSEL2, 1'b0);
    chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);

    // GPIO write, zero wait states: response two cycles after SETUP
    do_txn(1'b1, 32'h0, 32'hFFFF_0000, 32'hDEAD_BEEF, 0, 1'b0, 1, a, rc);
    chk32("wr_latency", 32'(last_rsp_cyc - a), 32'd2);
    chk32("wr_pwdata", bus.PWDATA, 32'hFFFF_0000);
    chk32("wr_rdata", bus.rsp_rdata, 32'h0);

    do_txn(1'b0, 32'h12, 32'h0, 32'hA5, 0, 1'b0, 1, a, rc);
    chk32("uart_paddr", bus.PADDR, 32'h2);
    chk32("uart_rdata", bus.rsp_rdata, 32'hA5);

    do_txn(1'b1, 32'h3C, 32'hCAFE_F00D, 32'h0, 3, 1'b0, 1, a, rc);
    chk32("wait3_latency", 32'(last_rsp_cyc - a), 32'd5);

    do_txn(1'b0, 32'h8, 32'h0, 32'h77, 0, 1'b1, 1, a, rc);
    chk1("err_flag", bus.rsp_err, 1'b1);
    chk1("err_idle", bus.req_ready, 1'b1);

    do_abort();

    do_txn(1'b0, 32'h4, 32'h0, 32'h55, 8, 1'b0, 1, a, rc);
`ifdef APB_TIMEOUT_EN
    chk32("tmo_latency", 32'(last_rsp_cyc - a), 32'(TMO + 1));
    chk1("tmo_err", bus.rsp_err, 1'b1);
    chk32("tmo_rdata", bus.rsp_rdata, 32'h0);
`else
    chk32("long_wait_latency", 32'(last_rsp_cyc - a), 32'd10);
    chk32("long_wait_rdata", bus.rsp_rdata, 32'h55);
`endif

    for (int k = 0; k < 200; k++) begin
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             $urandom_range(0, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 2), a, rc);
    end

    repeat (2) @(posedge PCLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB master that sits directly upstream of the GPIO port and UART slaves. It accepts single read/write requests on a simple valid/ready command interface and runs the APB SETUP/ACCESS protocol toward the selected slave. It then returns read data and error status on a one-cycle response strobe. It drives PSEL1 (GPIO) and PSEL2 (UART) and shares PADDR/PWRITE/PWDATA/PENABLE between them.

## Interface
- DATA_WIDTH, 32, width of PWDATA/PRDATA and request/response data
- ADDRESS_WIDTH, 32, width of req_addr and PADDR
- SEL_BIT, 4, req_addr bit selecting the slave: 0 selects GPIO (PSEL1), 1 selects UART (PSEL2)
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles with PREADY low; used only with APB_TIMEOUT_EN

Ports:
- PCLK  in  1  clock; all logic is rising-edge
- PRESET  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high together with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDRESS_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  slave error or timeout
- PADDR  out  ADDRESS_WIDTH  req_addr with SEL_BIT cleared (slave-local offset)
- PSEL1, PSEL2  out  1 each  slave selects
- PENABLE, PWRITE  out  1 each  APB control
- PWDATA  out  DATA_WIDTH  write data
- PRDATA1, PRDATA2  in  DATA_WIDTH  slave read data
- PREADY1, PREADY2  in  1 each  slave ready
- PSLVERR1, PSLVERR2  in  1 each  slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - req_ready=1, PSELx=0, PENABLE=0.
  - On req_valid: latch write/addr/wdata into PADDR/PWRITE/PWDATA, register the slave index from req_addr[SEL_BIT], go to SETUP.
- **SETUP**
  - Selected PSELx=1, PENABLE=0, req_ready=0.
  - Unconditionally go to ACCESS.
- **ACCESS**
  - Selected PSELx=1, PENABLE=1.
  - The PREADY/PRDATA/PSLVERR of the selected slave only are observed, through the mux.
  - When selected PREADY=1: rsp_valid←1, rsp_err←PSLVERR, rsp_rdata←(read ? PRDATA : 0), go to IDLE.
  - Otherwise remain in ACCESS.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the last ACCESS cycle. After completion they keep their last values; only the PSELs and PENABLE drop.
- Exactly one PSEL is high at any time; neither is high in IDLE.
- Simultaneous events:
  - req_valid during SETUP/ACCESS is ignored because req_ready=0.
  - The requester holds the request until accepted.
- Reset mid-transfer aborts immediately: no response is generated and the FSM returns to IDLE.
- Reset values: state IDLE, req_ready=1 from the first post-reset cycle, all other outputs 0.

## Timing
- Request accepted at edge E: SETUP during cycle E+1, ACCESS from E+2.
- With zero wait states, PREADY is sampled high at the end of the first ACCESS cycle. rsp_valid is then high in cycle E+3, together with req_ready=1.
- Each PREADY-low cycle adds one ACCESS cycle.
- Minimum request-to-request spacing is 3 cycles; there is no ACCESS→SETUP chaining.
- rsp_valid is high for exactly one cycle. rsp_rdata and rsp_err hold their values until the next response.

## Configuration
- **APB_TIMEOUT_EN defined**
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY low.
  - When the count equals TIMEOUT_CYCLES, the transfer terminates: rsp_valid=1, rsp_err=1, rsp_rdata=0, PSEL/PENABLE drop, and the FSM returns to IDLE.
  - A PREADY=1 in the same cycle as the limit wins, giving a normal completion.
- **APB_TIMEOUT_EN undefined**
  - No counter is present; ACCESS waits indefinitely.

## Structure
- Shared package apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS}
  - slave index constants SLV_GPIO=0, SLV_UART=1
- One sub-module, apb_slave_mux: a combinational selection of PREADY/PRDATA/PSLVERR by slave index.

## Test plan
- Write GPIO: req_addr=0x0, wdata=0xFFFF0000, PREADY1=1 → PSEL1 high for 2 cycles, PENABLE in the 2nd, PWDATA=0xFFFF0000, rsp_valid in cycle E+3 with rsp_err=0 and rsp_rdata=0.
- Read UART: req_addr=0x12 (SEL_BIT=1), PRDATA2=0xA5 → PADDR=0x02, PSEL2 only, rsp_rdata=0xA5.
- Wait states: PREADY2 low for 3 ACCESS cycles → rsp_valid in cycle E+6; PADDR/PWDATA stable throughout.
- Error: PSLVERR1=1 with PREADY1=1 → rsp_err=1, then IDLE.
- Reset in ACCESS: assert PRESET → next cycle PSELx=0, PENABLE=0, no rsp_valid, req_ready=1.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=4: PREADY held low → rsp_valid and rsp_err after 4 ACCESS cycles, rsp_rdata=0.
